frontend_fetch: RTL and testbench
=================================

# frontend_fetch

Frontend fetch stage that produces the two-slot instruction stream consumed by the instruction queue. Requests 64-bit aligned fetch blocks from the instruction cache, predecodes control flow, applies optional static branch prediction, and presents up to two instructions per block. Holds each block until the queue reports it consumed, and redirects on queue replay or backend flush.

## Interface
- BOOT_ADDR, default 64'h8000_0000 (truncated to VLEN): PC after reset.
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset, sampled on posedge clk_i.
- flush_i  in  1  backend redirect; highest priority.
- flush_pc_i  in  VLEN  redirect target.
- icache_req_o  out  1  fetch request valid.
- icache_addr_o  out  VLEN  request address, bits [2:0] forced 0.
- icache_ready_i  in  1  cache accepts request when req and ready are both high.
- icache_rvalid_i  in  1  response valid, one cycle.
- icache_rdata_i  in  64  fetch block; [31:0] = addr+0, [63:32] = addr+4.
- valid_o  out  2  slot valid mask toward the queue.
- instr_o  out  2x32  slot instructions.
- addr_o  out  2xVLEN  slot PCs.
- cf_type_o  out  2xcf_t  predecoded control-flow type.
- predict_address_o  out  2xVLEN  predicted next PC per slot.
- ready_i  in  1  queue not full (informational; no gating).
- consumed_i  in  2  per-slot accepted by queue this cycle.
- replay_i  in  1  queue rejected a slot; refetch from replay_addr_i.
- replay_addr_i  in  VLEN  refetch PC.

## Operation
- States: IDLE, REQ, WAIT, HOLD, KILL. Reset: state IDLE, pc = BOOT_ADDR, valid_o = 0, icache_req_o = 0, all data outputs 0.
- IDLE -> REQ unconditionally next cycle.
- REQ: icache_req_o = 1, icache_addr_o = {pc[VLEN-1:3],3'b0}. Handshake -> WAIT. At most one request outstanding.
- WAIT: on icache_rvalid_i, capture block into hold register -> HOLD.
- HOLD: valid_o driven from hold register. Slot 0 = word pc[2] selects; if pc[2]=1, slot 0 = upper word, addr pc, slot 1 invalid. Otherwise slot 0 = lower word (addr pc), slot 1 = upper word (addr pc+4).
- Predecode: opcode 1100011 -> Branch; 1101111 -> Jump; 1100111 with rd=x0, rs1=x1 -> Return; other 1100111 -> JumpR; else NoCF.
- Prediction: Jump predicted taken, target = addr + J-imm; Branch taken iff B-imm negative (BTFN), target = addr + B-imm; JumpR/Return/NoCF predict addr+4. If slot 0 predicted taken, slot 1 invalid.
- Next PC: predicted target of last valid slot if taken, else {pc[VLEN-1:3],3'b0}+8. Adders wrap modulo 2^VLEN.
- Consumption in HOLD: when consumed_i covers every bit of valid_o and replay_i=0, pc <= next PC, valid_o <= 0, -> REQ.
- Partial consumption (consumed_i[0] only): no state change unless replay_i; replay_i always accompanies it.
- replay_i in HOLD: pc <= replay_addr_i, valid_o <= 0, -> REQ. Replay ignored outside HOLD.
- flush_i any state: pc <= flush_pc_i, valid_o <= 0. From WAIT, or from REQ with handshake in same cycle -> KILL; otherwise -> REQ.
- KILL: wait for icache_rvalid_i, discard data, -> REQ. flush_i in KILL updates pc, stays KILL.
- Priority: rst_ni > flush_i > replay_i > consumption.

## Timing
- Request issue: REQ entered 1 cycle after leaving reset/redirect; req held high until handshake.
- valid_o rises the cycle after icache_rvalid_i; stays stable (all outputs) until consumed, replay or flush.
- Full consume at cycle t -> icache_req_o high at t+1.
- Replay or flush at t -> valid_o low at t+1, request for new PC at t+1 (t+1 after discarded response when via KILL).
- Unaligned replay_addr (pc[2]=1) yields single-slot block.

## Configuration
- FRONTEND_FETCH_STATIC_BP_EN defined: BTFN and Jump prediction as above, slot 1 suppressed after taken slot 0.
- Undefined: all slots predict addr+4, no slot suppression, next PC always aligned pc+8; predecode still drives cf_type_o.

## Structure
- config_pkg: VLEN, cf_t (NoCF, Branch, Jump, JumpR, Return), RISC-V opcode constants, fetch state enum.
- One sub-module: frontend_predecode (combinational; instr, addr -> cf type, taken, target), instantiated per slot.

## Test plan
- Reset, cache ready, 2-cycle response with 0x00000013 pair -> req addr 0x80000000, valid_o=2'b11, addr 0x80000000/0x80000004; consume both -> next req 0x80000008.
- Slot 0 = jal x0,-16 at 0x80000010 (macro on) -> valid_o=2'b01, predict 0x80000000, next req 0x80000000; macro off -> 2'b11, next req 0x80000018.
- consumed_i=2'b01 with replay_i, replay_addr 0x80000024 -> next req 0x80000020, then valid_o=2'b01 slot 0 addr 0x80000024.
- flush_i in WAIT to 0x80001000, stale rvalid 3 cycles later -> data dropped, valid_o stays 0, next req 0x80001000.
- Slot 0 bne with +8 offset (forward) -> not taken, valid_o=2'b11, predict addr+4; backward -8 -> taken, predict addr-8.
- rst_ni low mid-HOLD -> next cycle valid_o=0, icache_req_o=0, then request BOOT_ADDR.

Source files
------------

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared types and constants for the fetch frontend.
package config_pkg;

  localparam int unsigned VLEN = 64;

  typedef enum logic [2:0] {
    CF_NONE   = 3'd0,
    CF_BRANCH = 3'd1,
    CF_JUMP   = 3'd2,
    CF_JUMPR  = 3'd3,
    CF_RETURN = 3'd4
  } cf_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_KILL = 3'd4
  } fetch_state_e;

  // Base address of the 64-bit fetch block containing a.
  function automatic logic [VLEN-1:0] blk_base(input logic [VLEN-1:0] a);
    return {a[VLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/frontend_predecode.sv
// rtl/frontend_predecode.sv - per-slot control-flow predecode and static prediction.
// Prediction enabled only when FRONTEND_FETCH_STATIC_BP_EN is defined.
module frontend_predecode
  import config_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [VLEN-1:0] addr_i,
  output cf_t             cf_o,
  output logic            taken_o,
  output logic [VLEN-1:0] predict_o
);

  logic [VLEN-1:0] j_imm;
  logic [VLEN-1:0] b_imm;
  logic [VLEN-1:0] tgt;
  logic            cf_taken;

  assign j_imm = {{(VLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign b_imm = {{(VLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

  always_comb begin
    cf_o     = CF_NONE;
    cf_taken = 1'b0;
    tgt      = addr_i + VLEN'(4);
    case (instr_i[6:0])
      OPC_BRANCH: begin
        cf_o     = CF_BRANCH;
        cf_taken = instr_i[31];  // backward taken, forward not taken
        tgt      = addr_i + b_imm;
      end
      OPC_JAL: begin
        cf_o     = CF_JUMP;
        cf_taken = 1'b1;
        tgt      = addr_i + j_imm;
      end
      OPC_JALR: begin
        cf_o = (instr_i[11:7] == 5'd0 && instr_i[19:15] == 5'd1) ? CF_RETURN : CF_JUMPR;
      end
      default: ;
    endcase
  end

`ifdef FRONTEND_FETCH_STATIC_BP_EN
  assign taken_o = cf_taken;
`else
  assign taken_o = 1'b0;
`endif

  assign predict_o = taken_o ? tgt : addr_i + VLEN'(4);

endmodule

// File: rtl/frontend_fetch.sv
// rtl/frontend_fetch.sv - fetch FSM feeding a two-slot block to the instruction queue.
// FRONTEND_FETCH_STATIC_BP_EN enables static prediction inside frontend_predecode.
module frontend_fetch
  import config_pkg::*;
#(
  parameter logic [63:0] BOOT_ADDR = 64'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [VLEN-1:0]       flush_pc_i,
  output logic                  icache_req_o,
  output logic [VLEN-1:0]       icache_addr_o,
  input  logic                  icache_ready_i,
  input  logic                  icache_rvalid_i,
  input  logic [63:0]           icache_rdata_i,
  output logic [1:0]            valid_o,
  output logic [1:0][31:0]      instr_o,
  output logic [1:0][VLEN-1:0]  addr_o,
  output cf_t  [1:0]            cf_type_o,
  output logic [1:0][VLEN-1:0]  predict_address_o,
  input  logic                  ready_i,
  input  logic [1:0]            consumed_i,
  input  logic                  replay_i,
  input  logic [VLEN-1:0]       replay_addr_i
);

  localparam logic [VLEN-1:0] BOOT = BOOT_ADDR[VLEN-1:0];

  fetch_state_e            state_q;
  logic [VLEN-1:0]         pc_q, next_pc_q, raddr_q;
  logic                    req_q;
  logic [1:0]              valid_q;
  logic [1:0][31:0]        instr_q;
  logic [1:0][VLEN-1:0]    addr_q, pred_q;
  cf_t  [1:0]              cf_q;

  logic [31:0]     w0, w1;
  logic [VLEN-1:0] a0, a1, p0, p1, blk_next, next_pc;
  logic            t0, t1;
  cf_t             c0, c1;
  logic [1:0]      vmask;

  // Slot view of the incoming block, evaluated against pc_q at capture time.
  assign w0 = pc_q[2] ? icache_rdata_i[63:32] : icache_rdata_i[31:0];
  assign w1 = icache_rdata_i[63:32];
  assign a0 = pc_q;
  assign a1 = pc_q + VLEN'(4);

  frontend_predecode u_pd0 (.instr_i(w0), .addr_i(a0), .cf_o(c0), .taken_o(t0), .predict_o(p0));
  frontend_predecode u_pd1 (.instr_i(w1), .addr_i(a1), .cf_o(c1), .taken_o(t1), .predict_o(p1));

  always_comb begin
    vmask    = (pc_q[2] || t0) ? 2'b01 : 2'b11;
    blk_next = blk_base(pc_q) + VLEN'(8);
    if (vmask[1]) next_pc = t1 ? p1 : blk_next;
    else          next_pc = t0 ? p0 : blk_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= BOOT;
      next_pc_q <= '0;
      raddr_q   <= '0;
      req_q     <= 1'b0;
      valid_q   <= '0;
      instr_q   <= '0;
      addr_q    <= '0;
      pred_q    <= '0;
      cf_q      <= {CF_NONE, CF_NONE};
    end else if (flush_i) begin
      pc_q    <= flush_pc_i;
      valid_q <= '0;
      // A response still in flight must be drained before refetching.
      if (((state_q == S_WAIT || state_q == S_KILL) && !icache_rvalid_i) ||
          (state_q == S_REQ && icache_ready_i)) begin
        state_q <= S_KILL;
        req_q   <= 1'b0;
      end else begin
        state_q <= S_REQ;
        req_q   <= 1'b1;
        raddr_q <= blk_base(flush_pc_i);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          raddr_q <= blk_base(pc_q);
        end
        S_REQ: if (icache_ready_i) begin
          state_q <= S_WAIT;
          req_q   <= 1'b0;
        end
        S_WAIT: if (icache_rvalid_i) begin
          state_q   <= S_HOLD;
          valid_q   <= vmask;
          instr_q   <= {w1, w0};
          addr_q    <= {a1, a0};
          pred_q    <= {p1, p0};
          cf_q      <= {c1, c0};
          next_pc_q <= next_pc;
        end
        S_HOLD: begin
          if (replay_i) begin
            pc_q    <= replay_addr_i;
            valid_q <= '0;
            state_q <= S_REQ;
            req_q   <= 1'b1;
            raddr_q <= blk_base(replay_addr_i);
          end else if ((consumed_i & valid_q) == valid_q) begin
            pc_q    <= next_pc_q;
            valid_q <= '0;
            state_q <= S_REQ;
            req_q   <= 1'b1;
            raddr_q <= blk_base(next_pc_q);
          end
        end
        S_KILL: if (icache_rvalid_i) begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          raddr_q <= blk_base(pc_q);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign icache_req_o      = req_q;
  assign icache_addr_o     = raddr_q;
  assign valid_o           = valid_q;
  assign instr_o           = instr_q;
  assign addr_o            = addr_q;
  assign cf_type_o         = cf_q;
  assign predict_address_o = pred_q;

endmodule

// File: tb/tb_frontend_fetch.sv
// tb/tb_frontend_fetch.sv - scoreboard bench for frontend_fetch.
module tb_frontend_fetch;
  import config_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_ni = 1'b0;
  logic                 flush_i = 1'b0;
  logic [63:0]          flush_pc_i = '0;
  logic                 icache_req_o;
  logic [63:0]          icache_addr_o;
  logic                 icache_ready_i = 1'b0;
  logic                 icache_rvalid_i = 1'b0;
  logic [63:0]          icache_rdata_i = '0;
  logic [1:0]           valid_o;
  logic [1:0][31:0]     instr_o;
  logic [1:0][63:0]     addr_o;
  cf_t  [1:0]           cf_type_o;
  logic [1:0][63:0]     predict_address_o;
  logic                 ready_i = 1'b1;
  logic [1:0]           consumed_i = '0;
  logic                 replay_i = 1'b0;
  logic [63:0]          replay_addr_i = '0;

  frontend_fetch dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_ready_i(icache_ready_i), .icache_rvalid_i(icache_rvalid_i),
    .icache_rdata_i(icache_rdata_i), .valid_o(valid_o), .instr_o(instr_o),
    .addr_o(addr_o), .cf_type_o(cf_type_o), .predict_address_o(predict_address_o),
    .ready_i(ready_i), .consumed_i(consumed_i), .replay_i(replay_i),
    .replay_addr_i(replay_addr_i)
  );

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] JAL_M16 = 32'hff1f_f06f;
  localparam logic [31:0] BNE_P8 = 32'h0020_9463;
  localparam logic [31:0] BNE_M8 = 32'hfe20_9ce3;
  localparam logic [31:0] RET    = 32'h0000_8067;
`ifdef FRONTEND_FETCH_STATIC_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  typedef struct {
    logic [1:0]  v;
    logic [63:0] a0, a1, p0, p1;
    logic [31:0] i0;
    cf_t         c0, c1;
  } exp_t;

  logic [63:0] req_sb[$];
  exp_t        out_sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic exp_t mk(logic [1:0] v, logic [63:0] a0, logic [63:0] p0,
                              logic [63:0] p1, logic [31:0] i0, cf_t c0, cf_t c1);
    exp_t e;
    e.v = v; e.a0 = a0; e.a1 = a0 + 64'd4; e.p0 = p0; e.p1 = p1;
    e.i0 = i0; e.c0 = c0; e.c1 = c1;
    return e;
  endfunction

  // Scoreboard consumer: requests at handshake, slot contents when valid_o rises.
  logic [1:0] prev_v = '0;
  always begin
    @(negedge clk);
    #1;
    if (rst_ni && icache_req_o && icache_ready_i) begin
      n_cmp++;
      if (req_sb.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got addr=%h, expected no request", icache_addr_o);
      end else begin
        logic [63:0] ea;
        ea = req_sb.pop_front();
        if (icache_addr_o !== ea) begin
          n_err++;
          $display("FAIL req_addr: got %h, expected %h", icache_addr_o, ea);
        end
      end
    end
    if (valid_o != 2'b00 && prev_v == 2'b00) begin
      n_cmp++;
      if (out_sb.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got valid=%b, expected none", valid_o);
      end else begin
        exp_t e;
        e = out_sb.pop_front();
        if (valid_o !== e.v) begin
          n_err++;
          $display("FAIL valid: got %b, expected %b", valid_o, e.v);
        end
        n_cmp++;
        if (addr_o[0] !== e.a0 || instr_o[0] !== e.i0 || predict_address_o[0] !== e.p0 || cf_type_o[0] !== e.c0) begin
          n_err++;
          $display("FAIL slot0: got a=%h i=%h p=%h cf=%0d, expected a=%h i=%h p=%h cf=%0d",
                   addr_o[0], instr_o[0], predict_address_o[0], cf_type_o[0], e.a0, e.i0, e.p0, e.c0);
        end
        if (e.v[1]) begin
          n_cmp++;
          if (addr_o[1] !== e.a1 || predict_address_o[1] !== e.p1 || cf_type_o[1] !== e.c1) begin
            n_err++;
            $display("FAIL slot1: got a=%h p=%h cf=%0d, expected a=%h p=%h cf=%0d",
                     addr_o[1], predict_address_o[1], cf_type_o[1], e.a1, e.p1, e.c1);
          end
        end
      end
    end
    prev_v = valid_o;
  end

  task automatic serve(input logic [63:0] data, input int lat);
    int n = 0;
    while (icache_req_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL req_timeout: got no request, expected one within 50 cycles");
    end
    icache_ready_i = 1'b1;
    @(negedge clk);
    icache_ready_i = 1'b0;
    repeat (lat - 1) @(negedge clk);
    icache_rdata_i  = data;
    icache_rvalid_i = 1'b1;
    @(negedge clk);
    icache_rvalid_i = 1'b0;
  endtask

  task automatic consume(input logic [1:0] c, input logic rp, input logic [63:0] ra);
    consumed_i = c; replay_i = rp; replay_addr_i = ra;
    @(negedge clk);
    consumed_i = '0; replay_i = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] a);
    flush_i = 1'b1; flush_pc_i = a;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (valid_o !== 2'b00 || icache_req_o !== 1'b0 || instr_o !== '0 || addr_o !== '0 || predict_address_o !== '0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b req=%b, expected all zero", valid_o, icache_req_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic;
    req_sb.push_back(64'h8000_0000);
    out_sb.push_back(mk(2'b11, 64'h8000_0000, 64'h8000_0004, 64'h8000_0008, NOP, CF_NONE, CF_NONE));
    serve({NOP, NOP}, 2);
    consume(2'b11, 1'b0, '0);
    n_cmp++;
    if (valid_o !== 2'b00 || icache_req_o !== 1'b1 || icache_addr_o !== 64'h8000_0008) begin
      n_err++;
      $display("FAIL basic_next: got valid=%b req=%b addr=%h, expected 00 1 80000008", valid_o, icache_req_o, icache_addr_o);
    end
  endtask

  task automatic test_jal;
    logic [63:0] nxt;
    req_sb.push_back(64'h8000_0008);
    out_sb.push_back(mk(2'b11, 64'h8000_0008, 64'h8000_000c, 64'h8000_0010, NOP, CF_NONE, CF_NONE));
    serve({NOP, NOP}, 1);
    consume(2'b11, 1'b0, '0);
    req_sb.push_back(64'h8000_0010);
    out_sb.push_back(mk(BP ? 2'b01 : 2'b11, 64'h8000_0010, BP ? 64'h8000_0000 : 64'h8000_0014,
                        64'h8000_0018, JAL_M16, CF_JUMP, CF_NONE));
    serve({NOP, JAL_M16}, 2);
    consume(2'b11, 1'b0, '0);
    nxt = BP ? 64'h8000_0000 : 64'h8000_0018;
    n_cmp++;
    if (icache_req_o !== 1'b1 || icache_addr_o !== nxt) begin
      n_err++;
      $display("FAIL jal_next: got req=%b addr=%h, expected 1 %h", icache_req_o, icache_addr_o, nxt);
    end
  endtask

  task automatic test_replay;
    redirect(64'h8000_0020);
    req_sb.push_back(64'h8000_0020);
    out_sb.push_back(mk(2'b11, 64'h8000_0020, 64'h8000_0024, 64'h8000_0028, NOP, CF_NONE, CF_NONE));
    serve({ADDI, NOP}, 2);
    consume(2'b01, 1'b1, 64'h8000_0024);
    n_cmp++;
    if (valid_o !== 2'b00 || icache_req_o !== 1'b1 || icache_addr_o !== 64'h8000_0020) begin
      n_err++;
      $display("FAIL replay_req: got valid=%b req=%b addr=%h, expected 00 1 80000020", valid_o, icache_req_o, icache_addr_o);
    end
    req_sb.push_back(64'h8000_0020);
    out_sb.push_back(mk(2'b01, 64'h8000_0024, 64'h8000_0028, 64'h0, ADDI, CF_NONE, CF_NONE));
    serve({ADDI, NOP}, 3);
    consume(2'b01, 1'b0, '0);
    n_cmp++;
    if (icache_req_o !== 1'b1 || icache_addr_o !== 64'h8000_0028) begin
      n_err++;
      $display("FAIL replay_next: got req=%b addr=%h, expected 1 80000028", icache_req_o, icache_addr_o);
    end
  endtask

  task automatic test_flush_wait;
    req_sb.push_back(64'h8000_0028);
    icache_ready_i = 1'b1;
    @(negedge clk);
    icache_ready_i = 1'b0;
    redirect(64'h8000_1000);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (valid_o !== 2'b00 || icache_req_o !== 1'b0) begin
        n_err++;
        $display("FAIL kill_quiet%0d: got valid=%b req=%b, expected 00 0", i, valid_o, icache_req_o);
      end
      @(negedge clk);
    end
    icache_rdata_i  = {JAL_M16, JAL_M16};
    icache_rvalid_i = 1'b1;
    @(negedge clk);
    icache_rvalid_i = 1'b0;
    n_cmp++;
    if (valid_o !== 2'b00 || icache_req_o !== 1'b1 || icache_addr_o !== 64'h8000_1000) begin
      n_err++;
      $display("FAIL kill_drop: got valid=%b req=%b addr=%h, expected 00 1 80001000", valid_o, icache_req_o, icache_addr_o);
    end
  endtask

  task automatic test_branch;
    logic [63:0] nxt;
    req_sb.push_back(64'h8000_1000);
    out_sb.push_back(mk(2'b11, 64'h8000_1000, 64'h8000_1004, 64'h8000_1008, BNE_P8, CF_BRANCH, CF_RETURN));
    serve({RET, BNE_P8}, 2);
    consume(2'b11, 1'b0, '0);
    n_cmp++;
    if (icache_addr_o !== 64'h8000_1008) begin
      n_err++;
      $display("FAIL fwd_next: got %h, expected 80001008", icache_addr_o);
    end
    req_sb.push_back(64'h8000_1008);
    out_sb.push_back(mk(BP ? 2'b01 : 2'b11, 64'h8000_1008, BP ? 64'h8000_1000 : 64'h8000_100c,
                        64'h8000_1010, BNE_M8, CF_BRANCH, CF_RETURN));
    serve({RET, BNE_M8}, 2);
    consume(2'b11, 1'b0, '0);
    nxt = BP ? 64'h8000_1000 : 64'h8000_1010;
    n_cmp++;
    if (icache_req_o !== 1'b1 || icache_addr_o !== nxt) begin
      n_err++;
      $display("FAIL bwd_next: got req=%b addr=%h, expected 1 %h", icache_req_o, icache_addr_o, nxt);
    end
  endtask

  task automatic test_reset_hold;
    logic [63:0] a;
    a = BP ? 64'h8000_1000 : 64'h8000_1010;
    req_sb.push_back(a);
    out_sb.push_back(mk(2'b11, a, a + 64'd4, a + 64'd8, NOP, CF_NONE, CF_NONE));
    serve({NOP, NOP}, 2);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    n_cmp++;
    if (valid_o !== 2'b00 || icache_req_o !== 1'b0 || addr_o !== '0) begin
      n_err++;
      $display("FAIL hold_reset: got valid=%b req=%b, expected 00 0", valid_o, icache_req_o);
    end
    req_sb.push_back(64'h8000_0000);
    out_sb.push_back(mk(2'b11, 64'h8000_0000, 64'h8000_0004, 64'h8000_0008, NOP, CF_NONE, CF_NONE));
    serve({NOP, NOP}, 2);
    consume(2'b11, 1'b0, '0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_sb.size() != 0 || out_sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d req / %0d out left, expected 0 / 0", req_sb.size(), out_sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jal();
    test_replay();
    test_flush_wait();
    test_branch();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
